bus_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the RV32I core data bus, beside the data RAM.
//  The core writes bytes into a TX FIFO; a serializer FSM sends 8N1 frames on uart_tx.

---
 rtl/bus_uart_tx_pkg.sv | 26 ++
 rtl/bus_uart_tx_if.sv | 13 +
 rtl/bus_uart_tx_fifo.sv | 49 ++++
 rtl/bus_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_bus_uart_tx.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_uart_tx_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] BAUD_OFS   = 4'h8;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  // STATUS has only four bits for the fill level.
  function automatic logic [3:0] sat_count(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/bus_uart_tx_if.sv
// Core data-bus slice seen by the UART register block.
interface bus_uart_tx_if;
  // A write is taken on the rising edge where sel and bus_wren are both high;
  // there is no back-pressure, so rddata/sel are pure functions of bus_addr.
  logic [31:0] bus_addr;
  logic        bus_wren;
  logic [31:0] bus_wrdata;
  logic [31:0] rddata;
  logic        sel;

  modport master (output bus_addr, bus_wren, bus_wrdata, input rddata, sel);
  modport slave  (input bus_addr, bus_wren, bus_wrdata, output rddata, sel);
endinterface

// File: rtl/bus_uart_tx_fifo.sv
// Synchronous FIFO with first-word fall-through read data and an exact count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bus_uart_tx.sv
// UART transmitter on the core data bus: register decode, TX FIFO and 8N1 serializer.
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0400,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic          clk,
  input  logic          rst,
  bus_uart_tx_if.slave  bus,
  output logic          uart_tx,
  output logic          tx_busy,
  output uart_state_t   dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ofs;
  logic          sel_c;
  logic          wr_tx, wr_status, wr_baud;
  logic [15:0]   baud;
  logic          ovf;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic [31:0]   rdata_c;
  logic          unused_wrdata;

  uart_state_t state, state_n;
  logic [15:0] timer, timer_n, div_lat, div_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shifter, shift_n;
  logic        tx_q, tx_n;

  assign ofs       = bus.bus_addr - BASE_ADDR;
  assign sel_c     = (bus.bus_addr >= BASE_ADDR) && (ofs < 32'hC);
  assign wr_tx     = sel_c && bus.bus_wren && (ofs[3:2] == TXDATA_OFS[3:2]);
  assign wr_status = sel_c && bus.bus_wren && (ofs[3:2] == STATUS_OFS[3:2]);
  assign wr_baud   = sel_c && bus.bus_wren && (ofs[3:2] == BAUD_OFS[3:2]);
  assign unused_wrdata = ^bus.bus_wrdata[31:16];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .pop   (fifo_pop),
    .wdata (bus.bus_wrdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_busy   = (state != IDLE) || !fifo_empty;
  assign uart_tx   = tx_q;
  assign dbg_state = state;

  always_comb begin
    status                 = '0;
    status[ST_BUSY]        = tx_busy;
    status[ST_FULL]        = fifo_full;
    status[ST_EMPTY]       = fifo_empty;
    status[ST_OVF]         = ovf;
    status[ST_COUNT_LSB+:4] = sat_count(32'(fifo_count));
  end

  always_comb begin
    rdata_c = '0;
    if (sel_c) begin
      case (ofs[3:2])
        STATUS_OFS[3:2]: rdata_c = status;
        BAUD_OFS[3:2]:   rdata_c = {16'h0, baud};
        default:         rdata_c = '0;
      endcase
    end
  end

  assign bus.rddata = rdata_c;
  assign bus.sel    = sel_c;

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    div_n    = div_lat;
    bit_n    = bit_idx;
    shift_n  = shifter;
    tx_n     = tx_q;
    fifo_pop = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_rdata;
          div_n    = baud;
          timer_n  = baud - 16'd1;
          state_n  = START;
          tx_n     = 1'b0;
        end
      end
      START: begin
        if (timer == 16'd0) begin
          state_n = DATA;
          bit_n   = 3'd0;
          tx_n    = shifter[0];
          timer_n = div_lat - 16'd1;
        end else timer_n = timer - 16'd1;
      end
      DATA: begin
        if (timer == 16'd0) begin
          timer_n = div_lat - 16'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shift_n = shifter >> 1;
            tx_n    = shifter[1];
          end
        end else timer_n = timer - 16'd1;
      end
      STOP: begin
        if (timer == 16'd0) begin
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_n  = fifo_rdata;
            div_n    = baud;
            timer_n  = baud - 16'd1;
            state_n  = START;
            tx_n     = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else timer_n = timer - 16'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      timer   <= '0;
      div_lat <= DEFAULT_DIV;
      bit_idx <= '0;
      shifter <= '0;
      tx_q    <= 1'b1;
      baud    <= DEFAULT_DIV;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      div_lat <= div_n;
      bit_idx <= bit_n;
      shifter <= shift_n;
      tx_q    <= tx_n;
      if (wr_baud)
        baud <= (bus.bus_wrdata[15:0] == 16'd0) ? 16'd1 : bus.bus_wrdata[15:0];
      if (wr_status && bus.bus_wrdata[ST_OVF]) ovf <= 1'b0;
      else if (wr_tx && fifo_full && !fifo_pop) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: waveform-level line model plus directed literal checks.
module tb_bus_uart_tx;
  import uart_pkg::*;

  localparam logic [31:0] BASE  = 32'h1001_0400;
  localparam int          DEPTH = 8;
  localparam logic [31:0] TXA   = BASE + 32'h0;
  localparam logic [31:0] STA   = BASE + 32'h4;
  localparam logic [31:0] BDA   = BASE + 32'h8;

  logic        clk;
  logic        rst;
  logic        uart_tx;
  logic        tx_busy;
  uart_state_t dbg_state;

  bus_uart_tx_if bus_i ();

  bus_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_i),
    .uart_tx   (uart_tx),
    .tx_busy   (tx_busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: byte queue for the FIFO, per-cycle line level queue for frames in flight.
  logic [7:0]  exp_q[$];
  logic        line_q[$];
  logic [15:0] baud_m;
  logic        ovf_m;
  logic        exp_tx;
  logic        exp_busy;
  logic        live = 1'b0;
  logic [7:0]  mb;
  logic [31:0] moff;
  logic        msel;

  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      line_q.delete();
      baud_m   = 16'd434;
      ovf_m    = 1'b0;
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      live     = 1'b1;
    end else if (live) begin
      if (line_q.size() == 0 && exp_q.size() > 0) begin
        mb = exp_q.pop_front();
        for (int k = 0; k < int'(baud_m); k++) line_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < int'(baud_m); k++) line_q.push_back(mb[i]);
        for (int k = 0; k < int'(baud_m); k++) line_q.push_back(1'b1);
      end
      msel = (bus_i.bus_addr >= BASE) && (bus_i.bus_addr < BASE + 32'hC);
      moff = bus_i.bus_addr - BASE;
      if (msel && bus_i.bus_wren) begin
        case (moff[3:2])
          2'd0: if (exp_q.size() < DEPTH) exp_q.push_back(bus_i.bus_wrdata[7:0]);
                else ovf_m = 1'b1;
          2'd1: if (bus_i.bus_wrdata[3]) ovf_m = 1'b0;
          2'd2: baud_m = (bus_i.bus_wrdata[15:0] == 16'd0) ? 16'd1 : bus_i.bus_wrdata[15:0];
          default: ;
        endcase
      end
      if (line_q.size() > 0) begin
        exp_tx   = line_q.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = (exp_q.size() > 0);
      end
    end
  end

  // Compare process: every cycle, mid-period.
  logic [31:0] c_off;
  logic        c_sel;
  logic [31:0] c_rd;
  logic [31:0] c_st;
  always @(negedge clk) begin
    if (live && rst) begin
      c_sel = (bus_i.bus_addr >= BASE) && (bus_i.bus_addr < BASE + 32'hC);
      c_off = bus_i.bus_addr - BASE;
      c_st  = {24'h0, (exp_q.size() > 15) ? 4'hF : 4'(exp_q.size()), ovf_m,
               exp_q.size() == 0, exp_q.size() == DEPTH, exp_busy};
      c_rd  = 32'h0;
      if (c_sel) begin
        if (c_off[3:2] == 2'd1) c_rd = c_st;
        else if (c_off[3:2] == 2'd2) c_rd = {16'h0, baud_m};
      end
      check("m_uart_tx", 32'(uart_tx), 32'(exp_tx));
      check("m_tx_busy", 32'(tx_busy), 32'(exp_busy));
      check("m_sel", 32'(bus_i.sel), 32'(c_sel));
      check("m_rddata", bus_i.rddata, c_rd);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus_i.bus_addr   = a;
    bus_i.bus_wren   = 1'b1;
    bus_i.bus_wrdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus_i.bus_addr   = 32'h0;
      bus_i.bus_wren   = 1'b0;
      bus_i.bus_wrdata = 32'h0;
    end
  endtask

  task automatic read_check(input string name, input logic [31:0] a,
                            input logic [31:0] exp, input logic exp_sel);
    @(posedge clk); #1;
    bus_i.bus_addr = a;
    bus_i.bus_wren = 1'b0;
    #1;
    check(name, bus_i.rddata, exp);
    check({name, "_sel"}, 32'(bus_i.sel), 32'(exp_sel));
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while (tx_busy !== 1'b0 && k < max_cycles) begin
      @(posedge clk); #2;
      k++;
    end
    check("wait_idle", 32'(tx_busy), 32'h0);
  endtask

  // ---------------- directed stimulus ----------------
  logic t1_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst              = 1'b0;
    bus_i.bus_addr   = 32'h0;
    bus_i.bus_wren   = 1'b0;
    bus_i.bus_wrdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_uart_tx", 32'(uart_tx), 32'h1);
    check("rst_busy", 32'(tx_busy), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    read_check("rst_status", STA, 32'h4, 1'b1);
    read_check("rst_baud", BDA, 32'd434, 1'b1);

    // 1: A5 at divisor 4
    bus_write(BDA, 32'd4);
    bus_write(TXA, 32'hA5);
    idle(1);
    @(posedge clk); #2;
    check("t1_start", 32'(uart_tx), 32'h0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(posedge clk);
      #2 check("t1_bit", 32'(uart_tx), 32'(t1_bits[i]));
    end
    repeat (4) @(posedge clk);
    #2 check("t1_stop", 32'(uart_tx), 32'h1);
    repeat (3) @(posedge clk);
    #2 check("t1_busy_last", 32'(tx_busy), 32'h1);
    @(posedge clk);
    #2 check("t1_busy_fall", 32'(tx_busy), 32'h0);

    // 2: FIFO fill, overflow and OVF clear
    for (int i = 0; i < 9; i++) bus_write(TXA, 32'h10 + 32'(i));
    idle(1);
    read_check("t2_nine_fit", STA, 32'h83, 1'b1);
    wait_idle(600);
    for (int i = 0; i < 10; i++) bus_write(TXA, 32'h40 + 32'(i));
    idle(1);
    read_check("t2_ovf_set", STA, 32'h8B, 1'b1);
    bus_write(STA, 32'h8);
    idle(1);
    read_check("t2_ovf_clr", STA, 32'h83, 1'b1);
    wait_idle(600);

    // 3: back-to-back frames without an idle cycle
    bus_write(TXA, 32'h00);
    bus_write(TXA, 32'hFF);
    idle(1);
    repeat (39) @(posedge clk);
    #2 check("t3_stop", 32'(uart_tx), 32'h1);
    @(posedge clk);
    #2 check("t3_no_gap", 32'(uart_tx), 32'h0);
    check("t3_busy", 32'(tx_busy), 32'h1);
    wait_idle(200);

    // 4: BAUD 0 stores 1; mid-frame BAUD change applies to next frame only
    bus_write(BDA, 32'd0);
    idle(1);
    read_check("t4_baud0", BDA, 32'd1, 1'b1);
    bus_write(BDA, 32'd4);
    bus_write(TXA, 32'h0F);
    idle(1);
    bus_write(BDA, 32'd8);
    bus_write(TXA, 32'hF1);
    idle(1);
    repeat (2) @(posedge clk);
    #2 check("t4_old_div", 32'(uart_tx), 32'h1);
    repeat (36) @(posedge clk);
    #2 check("t4_next_start", 32'(uart_tx), 32'h0);
    repeat (7) @(posedge clk);
    #2 check("t4_new_div", 32'(uart_tx), 32'h0);
    @(posedge clk);
    #2 check("t4_bit0", 32'(uart_tx), 32'h1);
    wait_idle(200);

    // 5: reset in the middle of a data bit with bytes queued
    bus_write(BDA, 32'd4);
    bus_write(TXA, 32'h3C);
    bus_write(TXA, 32'h01);
    bus_write(TXA, 32'h02);
    bus_write(TXA, 32'h03);
    idle(1);
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    bus_i.bus_addr = STA;
    #1;
    check("t5_uart_tx", 32'(uart_tx), 32'h1);
    check("t5_busy", 32'(tx_busy), 32'h0);
    check("t5_status", bus_i.rddata, 32'h4);
    bus_i.bus_addr = BDA;
    #1 check("t5_baud", bus_i.rddata, 32'd434);
    idle(1);
    bus_write(BDA, 32'd4);
    idle(1);

    // 6: out-of-window addresses
    read_check("t6_base10", BASE + 32'h10, 32'h0, 1'b0);
    read_check("t6_basec", BASE + 32'hC, 32'h0, 1'b0);
    read_check("t6_ram", 32'h1000_0008, 32'h0, 1'b0);
    bus_write(BASE + 32'h10, 32'h55);
    bus_write(32'h1000_0000, 32'h66);
    bus_write(BASE + 32'hC, 32'h77);
    bus_write(BASE - 32'h4, 32'h1);
    idle(1);
    read_check("t6_fifo_same", STA, 32'h4, 1'b1);
    idle(3);
    check("t6_line_idle", 32'(uart_tx), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
